// File: rtl/adder_measure_sequencer.sv
// Delay-measurement sequencer for the instrumented Sklansky adder: load, settle, ring run, drain, capture.
// Optional multi-pass accumulation is enabled by defining ADDER_MEAS_REPEAT_EN.
module adder_measure_sequencer #(
  parameter int WIDTH      = 32,
  parameter int CNT_W      = 24,
  parameter int WIN_W      = 16,
  parameter int SETTLE_CYC = 2,
  parameter int DRAIN_CYC  = 2,
  parameter int REPEATS    = 4
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   cfg_a,
  input  logic [WIDTH-1:0]   cfg_b,
  input  logic [WIDTH-1:0]   cfg_ext_bit,
  input  logic [WIDTH-1:0]   cfg_ring_bit,
  input  logic [WIN_W-1:0]   cfg_window,
  input  logic [CNT_W-1:0]   cnt_value,
  input  logic [WIDTH-1:0]   s_output,
  output logic [WIDTH-1:0]   a_input,
  output logic [WIDTH-1:0]   b_input,
  output logic [WIDTH-1:0]   a_input_ext_bit_b,
  output logic [WIDTH-1:0]   a_input_ring_bit_b,
  output logic               cnt_clear,
  output logic               cnt_run,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result_sum,
  output logic [CNT_W+7:0]   result_count
);

  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, RUN, DRAIN, CAPTURE} state_t;

  if (SETTLE_CYC < 1 || DRAIN_CYC < 1 || REPEATS < 1 || REPEATS > 255) begin : g_bad_param
    $error("adder_measure_sequencer: parameter out of range");
  end

  state_t           state;
  logic [WIDTH-1:0] ring_lat;
  logic [WIN_W-1:0] win_lat;
  logic [WIN_W-1:0] timer;
  logic [WIN_W-1:0] run_last;

  // A zero window still runs for one cycle.
  assign run_last = (win_lat == '0) ? '0 : win_lat - 1'b1;

`ifdef ADDER_MEAS_REPEAT_EN
  logic [7:0]       pass;
  logic [CNT_W+7:0] acc;
  logic [CNT_W+8:0] acc_sum;
  logic [CNT_W+7:0] acc_sat;

  assign acc_sum = {1'b0, acc} + {9'd0, cnt_value};
  assign acc_sat = acc_sum[CNT_W+8] ? '1 : acc_sum[CNT_W+7:0];
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state              <= IDLE;
      ring_lat           <= '0;
      win_lat            <= '0;
      timer              <= '0;
      a_input            <= '0;
      b_input            <= '0;
      a_input_ext_bit_b  <= '0;
      a_input_ring_bit_b <= '0;
      cnt_clear          <= 1'b0;
      cnt_run            <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      result_sum         <= '0;
      result_count       <= '0;
`ifdef ADDER_MEAS_REPEAT_EN
      pass               <= '0;
      acc                <= '0;
`endif
    end else if (abort && state != IDLE) begin
      // Operands stay on the adder; results keep the last completed measurement.
      state              <= IDLE;
      a_input_ring_bit_b <= '0;
      cnt_clear          <= 1'b0;
      cnt_run            <= 1'b0;
      busy               <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start && !abort) begin
          a_input           <= cfg_a;
          b_input           <= cfg_b;
          a_input_ext_bit_b <= cfg_ext_bit;
          ring_lat          <= cfg_ring_bit;
          win_lat           <= cfg_window;
          done              <= 1'b0;
          busy              <= 1'b1;
          cnt_clear         <= 1'b1;
          state             <= LOAD;
`ifdef ADDER_MEAS_REPEAT_EN
          pass              <= '0;
          acc               <= '0;
`endif
        end
        LOAD: begin
          cnt_clear          <= 1'b0;
          a_input_ring_bit_b <= ring_lat;
          timer              <= WIN_W'(SETTLE_CYC - 1);
          state              <= SETTLE;
        end
        SETTLE: if (timer == '0) begin
          cnt_run <= 1'b1;
          timer   <= run_last;
          state   <= RUN;
        end else begin
          timer <= timer - 1'b1;
        end
        RUN: if (timer == '0) begin
          cnt_run <= 1'b0;
          timer   <= WIN_W'(DRAIN_CYC - 1);
          state   <= DRAIN;
        end else begin
          timer <= timer - 1'b1;
        end
        DRAIN: if (timer == '0) begin
          state <= CAPTURE;
        end else begin
          timer <= timer - 1'b1;
        end
        CAPTURE: begin
          a_input_ring_bit_b <= '0;
`ifdef ADDER_MEAS_REPEAT_EN
          if (pass < 8'(REPEATS - 1)) begin
            pass      <= pass + 1'b1;
            acc       <= acc_sat;
            cnt_clear <= 1'b1;
            state     <= LOAD;
          end else begin
            result_sum   <= s_output;
            result_count <= acc_sat;
            busy         <= 1'b0;
            done         <= 1'b1;
            state        <= IDLE;
          end
`else
          result_sum   <= s_output;
          result_count <= {8'd0, cnt_value};
          busy         <= 1'b0;
          done         <= 1'b1;
          state        <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
